// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared encodings for the multicycle RV32I control sequencer
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps ALUOp and funct fields onto the shared ALU operation
module mc_alu_decoder
    import riscv_mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [1:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        // Reported independently of alu_op so DECODE can vet R/I encodings early.
        funct_illegal = !(funct3 == 3'b000 || funct3 == 3'b110 || funct3 == 3'b111);
        alu_control   = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore sequencer stepping the shared memory/ALU datapath
module multicycle_control_fsm
    import riscv_mc_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] Instr,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ALUControl,
    output logic             RegWrite,
    output logic             InstrDone,
    output logic             Illegal,
    output logic [3:0]       State
);

    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign op     = Instr[6:0];
    assign funct3 = Instr[14:12];
    assign funct7 = Instr[31:25];
    assign unused_instr_bits = ^{Instr[24:15], Instr[11:7]};

    state_t     state;
    logic       illegal_q;
    alu_op_t    alu_op;
    logic       pc_update;
    logic       branch;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       funct_illegal;
    logic       decode_illegal;
    logic [1:0] alu_control;

    mc_alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct3        (funct3),
        .op5           (op[5]),
        .funct7b5      (Instr[30]),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        decode_illegal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_JAL: decode_illegal = 1'b0;
            OP_RTYPE: decode_illegal = funct_illegal ||
                                       !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
            OP_ITYPE: decode_illegal = funct_illegal;
            OP_BEQ:   decode_illegal = (funct3 != 3'b000);
            default:  decode_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if (decode_illegal) begin
                        state     <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        case (op)
                            OP_LW, OP_SW: state <= S_MEMADR;
                            OP_RTYPE:     state <= S_EXECR;
                            OP_ITYPE:     state <= S_EXECI;
                            OP_JAL:       state <= S_JAL;
                            OP_BEQ:       state <= S_BEQ;
                            default:      state <= S_TRAP;
                        endcase
                    end
                end
                S_MEMADR:   state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= S_FETCH;
                S_EXECR, S_EXECI, S_JAL: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        alu_op      = ALUOP_ADD;
        pc_update   = 1'b0;
        branch      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        case (state)
            S_FETCH: begin
                ir_write_s = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by rst so a mid-instruction reset cannot commit state.
    assign PCWrite    = !rst && (pc_update || (branch && Zero));
    assign IRWrite    = !rst && ir_write_s;
    assign MemWrite   = !rst && mem_write_s;
    assign RegWrite   = !rst && reg_write_s;
    assign ImmSrc     = imm_src_of(op);
    assign ALUControl = alu_control;
    assign InstrDone  = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                        (state == S_ALUWB) || (state == S_BEQ);
    assign Illegal    = illegal_q;
    assign State      = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed vectors for the multicycle control sequencer
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr;
    logic        Zero;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl;
    logic [3:0]  State;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] I_LW   = 32'h00812083;
    localparam logic [31:0] I_SW   = 32'h00112423;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_ADDI = 32'hFFF10093;
    localparam logic [31:0] I_ORI  = 32'h00616093;
    localparam logic [31:0] I_ANDI = 32'h00617093;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h010000EF;

    multicycle_control_fsm #(.width(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .Instr      (Instr),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .InstrDone  (InstrDone),
        .Illegal    (Illegal),
        .State      (State)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH; seq holds the expected state per cycle, one nibble each, LSB first.
    task automatic run_path(input string tag, input logic [31:0] ins, input logic z,
                            input int n, input logic [31:0] seq);
        int done;
        done  = 0;
        Instr = ins;
        Zero  = z;
        #1;
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_state"}, 32'(State), 32'(seq[4*i +: 4]));
            done += int'(InstrDone);
            tick();
        end
        check_eq({tag, "_done_count"}, done, 1);
        check_eq({tag, "_back_to_fetch"}, 32'(State), 0);
    endtask

    task automatic trap_case(input string tag, input logic [31:0] ins);
        Instr = ins;
        Zero  = 1'b1;
        tick();
        check_eq({tag, "_decode_illegal"}, 32'(Illegal), 0);
        tick();
        check_eq({tag, "_trap_state"}, 32'(State), 15);
        check_eq({tag, "_trap_flag"}, 32'(Illegal), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq({tag, "_trap_hold"},
                     32'({State, Illegal, PCWrite, IRWrite, MemWrite, RegWrite, InstrDone}),
                     32'h3E0);
        end
        rst = 1'b1;
        tick();
        check_eq({tag, "_rst_state"}, 32'(State), 0);
        check_eq({tag, "_rst_flag"}, 32'(Illegal), 0);
        rst  = 1'b0;
        Zero = 1'b0;
        #1;
    endtask

    logic [31:0] alu_ins  [7] = '{I_ADD, I_SUB, I_AND, I_OR, I_ADDI, I_ORI, I_ANDI};
    logic [1:0]  alu_exp  [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
    logic [3:0]  alu_st   [7] = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd8, 4'd8, 4'd8};

    initial begin
        rst   = 1'b1;
        Instr = I_LW;
        Zero  = 1'b0;
        tick();
        tick();
        check_eq("reset_state", 32'(State), 0);
        check_eq("reset_irwrite_forced", 32'(IRWrite), 0);
        check_eq("reset_pcwrite_forced", 32'(PCWrite), 0);
        check_eq("reset_illegal", 32'(Illegal), 0);
        rst = 1'b0;
        #1;
        check_eq("fetch_irwrite", 32'(IRWrite), 1);
        check_eq("fetch_pcwrite", 32'(PCWrite), 1);
        check_eq("fetch_srcs", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 32'b0_00_10_10);

        // Reset landing in the middle of a load.
        tick();
        check_eq("lw_decode_state", 32'(State), 1);
        check_eq("lw_decode_imm", 32'(ImmSrc), 0);
        check_eq("decode_srcs", 32'({ALUSrcA, ALUSrcB, ALUControl}), 32'b01_01_00);
        tick();
        check_eq("memadr_srca", 32'({State, ALUSrcA, ALUSrcB}), 32'b0010_10_01);
        tick();
        check_eq("memread_adrsrc", 32'({State, AdrSrc}), 32'b0011_1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("midrst_state", 32'(State), 0);
            check_eq("midrst_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 0);
        end
        rst = 1'b0;
        #1;
        check_eq("rst_release_irwrite", 32'({State, IRWrite}), 32'b0000_1);

        // Full load with per-state detail.
        tick();
        tick();
        tick();
        tick();
        check_eq("memwb_outputs", 32'({State, RegWrite, ResultSrc, InstrDone}), 32'b0100_1_01_1);
        tick();
        check_eq("lw_return", 32'({State, InstrDone}), 0);

        run_path("lw", I_LW, 1'b0, 5, 32'h43210);
        run_path("sw", I_SW, 1'b0, 4, 32'h5210);
        run_path("sub", I_SUB, 1'b0, 4, 32'h7610);
        run_path("addi", I_ADDI, 1'b0, 4, 32'h7810);
        run_path("jal", I_JAL, 1'b0, 4, 32'h7910);
        run_path("beq_nt", I_BEQ, 1'b0, 3, 32'hA10);

        Instr = I_SW;
        tick();
        check_eq("sw_decode_imm", 32'(ImmSrc), 1);
        tick();
        tick();
        check_eq("memwrite_outputs", 32'({State, MemWrite, AdrSrc, InstrDone}), 32'b0101_1_1_1);
        tick();

        for (int k = 0; k < 7; k++) begin
            Instr = alu_ins[k];
            tick();
            tick();
            check_eq($sformatf("alu_state_%0d", k), 32'(State), 32'(alu_st[k]));
            check_eq($sformatf("alu_ctl_%0d", k), 32'(ALUControl), 32'(alu_exp[k]));
            tick();
            check_eq($sformatf("aluwb_%0d", k), 32'({State, RegWrite, ResultSrc}), 32'b0111_1_00);
            tick();
        end

        Instr = I_BEQ;
        Zero  = 1'b1;
        tick();
        check_eq("beq_decode", 32'({ImmSrc, PCWrite}), 32'b10_0);
        tick();
        check_eq("beq_taken", 32'({State, PCWrite, ALUControl, InstrDone}), 32'b1010_1_01_1);
        tick();
        Zero = 1'b0;
        tick();
        tick();
        check_eq("beq_not_taken", 32'({State, PCWrite}), 32'b1010_0);
        tick();
        check_eq("beq_nt_return", 32'(State), 0);

        Instr = I_JAL;
        tick();
        check_eq("jal_decode_imm", 32'(ImmSrc), 3);
        tick();
        check_eq("jal_state", 32'({State, PCWrite, ALUSrcA, ALUSrcB}), 32'b1001_1_01_10);
        tick();
        check_eq("jal_aluwb", 32'({State, RegWrite}), 32'b0111_1);
        tick();

        // Garbage on Instr during FETCH must not steer the decode.
        Instr = 32'h0000007F;
        tick();
        Instr = I_ADD;
        tick();
        check_eq("fetch_insensitive", 32'({State, Illegal}), 32'b0110_0);
        tick();
        tick();

        trap_case("bad_opcode", 32'h0000007F);
        trap_case("r_funct3", 32'h002091B3);
        trap_case("beq_funct3", 32'h00209463);
        trap_case("r_funct7", 32'h202081B3);
        trap_case("i_funct3", 32'h00111093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control sequencer for the multicycle RV32I datapath, which shares one memory and one ALU across fetch, address and execute steps.
- It decodes the instruction register contents and steps a Moore state machine through Fetch/Decode/Execute/Memory/Writeback.
- Each state drives the mux selects and write enables that sequence the shared resources.
- Supports lw, sw, R-type (add/sub/and/or), I-type ALU (addi/andi/ori), beq and jal. Any other encoding traps.

Parameters:
- width, 32, instruction width in bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- Instr  input  width  instruction register output; valid from Decode onward
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register (and OldPC) enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  output  2  ALU operand B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  output  2  ALU operation: 00 = add, 01 = sub, 10 = and, 11 = or
- RegWrite  output  1  register file write enable
- InstrDone  output  1  one-cycle pulse in the final state of each instruction
- Illegal  output  1  sticky trap flag
- State  output  4  current state encoding, for debug

Behaviour:
- Clock and reset: single clk; rst is synchronous, active-high.
- Reset:
  - State register resets to FETCH (0); Illegal resets to 0.
  - While rst=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally, including when rst is asserted mid-instruction.
  - The first fetch occurs in the first cycle after rst falls.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=15.
- Outputs are Moore (state only), except:
  - ImmSrc is decoded from opcode.
  - ALUControl comes from the ALU decoder.
  - PCWrite = PCUpdate | (Branch & Zero).
  - Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add. Computes the branch/jump target into ALUOut.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE: lw/sw->MEMADR; R-type->EXECR; I-ALU->EXECI; jal->JAL; beq->BEQ; anything else->TRAP.
  - MEMADR: lw->MEMREAD; sw->MEMWRITE.
  - MEMREAD->MEMWB->FETCH.
  - MEMWRITE->FETCH.
  - EXECR->ALUWB; EXECI->ALUWB; JAL->ALUWB.
  - ALUWB->FETCH.
  - BEQ->FETCH.
  - TRAP->TRAP until rst.
- Illegal detection in DECODE covers:
  - unknown opcode;
  - R/I funct3 not in {000, 110, 111};
  - beq with funct3 != 000;
  - R-type funct7 other than 0000000 or 0100000.
  - On detection, Illegal is set on entry to TRAP and stays set until rst.
  - TRAP drives all enables to 0.
- ALU decoder:
  - ALUOp add->00; sub->01.
  - funct path:
    - funct3=000 -> sub (01) only if Instr[5]&Instr[30], else add.
    - funct3=110 -> or (11).
    - funct3=111 -> and (10).
  - addi with Instr[30]=1 is still add.
- InstrDone: high in MEMWB, MEMWRITE, ALUWB and BEQ.
- Latency per instruction: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
- Instr is sampled only in DECODE and later states; changes to Instr during FETCH have no effect on control.

Decomposition:
- Shared package riscv_mc_pkg:
  - state encodings, opcode constants (LW, SW, RTYPE, ITYPE, BEQ, JAL);
  - ALUOp and ALUControl codes;
  - ResultSrc, ALUSrcA and ALUSrcB select constants.
- One combinational sub-module, mc_alu_decoder (inputs ALUOp, funct3, op5, funct7b5; outputs ALUControl and a funct-illegal flag), instantiated by the FSM.

Test Plan:
- rst high 3 cycles in MEMREAD, then low -> State=0, IRWrite=1 next cycle; no RegWrite or MemWrite pulse during reset.
- lw x1,8(x2) (0x00812083) -> states 0,1,2,3,4; AdrSrc=1 in state 3; RegWrite=1 and ResultSrc=01 in state 4; InstrDone once.
- sub x3,x1,x2 (0x402081B3) -> EXECR with ALUControl=01, then ALUWB with RegWrite=1; or (funct3=110) -> ALUControl=11.
- beq with Zero=1 -> PCWrite=1 in BEQ, ALUControl=01; with Zero=0 -> PCWrite=0, return to FETCH after 3 cycles.
- jal x1,16 (0x010000EF) -> DECODE ImmSrc=11, JAL PCWrite=1, ALUWB RegWrite=1.
- opcode 0x7F or R-type funct3=001 -> TRAP (State=15), Illegal=1, all enables 0 for 20 cycles until rst.
